// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between IF fetches and MEM loads/stores, MEM first.
// Define MEM_BUS_TIMEOUT_EN to abort transactions that see no ack within TIMEOUT busy cycles.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        stallreq_o,
  output logic        bus_err_o
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;
  state_t state, state_n;
  logic ce_n, we_n, if_rdy_n, mem_rdy_n, err_n, ack, abort, done;
  logic [3:0] sel_n;
  logic [31:0] addr_n, wdata_n, if_data_n, mem_data_n, rdata;
`ifdef MEM_BUS_TIMEOUT_EN
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else if (!bus_ack_i) cnt <= cnt + 8'd1;
  // an ack arriving in the expiry cycle still completes normally
  assign abort = (state != IDLE) & ~bus_ack_i & (cnt == 8'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign abort = 1'b0;
`endif
  assign ack = bus_ce_o & bus_ack_i;
  assign done = ack | abort;
  assign rdata = abort ? 32'h0 : bus_data_i;
  assign stallreq_o = ~rst & ((if_ce_i & ~if_ready_o) | (mem_ce_i & ~mem_ready_o));
  always_comb begin
    state_n = state;
    ce_n = bus_ce_o;
    we_n = bus_we_o;
    sel_n = bus_sel_o;
    addr_n = bus_addr_o;
    wdata_n = bus_data_o;
    if_data_n = if_data_o;
    mem_data_n = mem_data_o;
    if_rdy_n = 1'b0;
    mem_rdy_n = 1'b0;
    err_n = 1'b0;
    if (state == IDLE) begin
      // a requester seeing its ready pulse this cycle is not re-served
      if (mem_ce_i && !mem_ready_o) begin
        state_n = MEM_BUSY;
        ce_n = 1'b1;
        we_n = mem_we_i;
        sel_n = mem_sel_i;
        addr_n = mem_addr_i;
        wdata_n = mem_data_i;
      end else if (if_ce_i && !if_ready_o) begin
        state_n = IF_BUSY;
        ce_n = 1'b1;
        we_n = 1'b0;
        sel_n = 4'b1111;
        addr_n = if_addr_i;
        wdata_n = 32'h0;
      end
    end else if (done) begin
      state_n = IDLE;
      ce_n = 1'b0;
      we_n = 1'b0;
      err_n = abort;
      if (state == IF_BUSY) begin
        if_rdy_n = 1'b1;
        if_data_n = rdata;
      end else begin
        mem_rdy_n = 1'b1;
        mem_data_n = (bus_we_o && !abort) ? mem_data_o : rdata;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus_ce_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_sel_o <= '0;
      bus_addr_o <= '0;
      bus_data_o <= '0;
      if_data_o <= '0;
      mem_data_o <= '0;
      if_ready_o <= 1'b0;
      mem_ready_o <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      state <= state_n;
      bus_ce_o <= ce_n;
      bus_we_o <= we_n;
      bus_sel_o <= sel_n;
      bus_addr_o <= addr_n;
      bus_data_o <= wdata_n;
      if_data_o <= if_data_n;
      mem_data_o <= mem_data_n;
      if_ready_o <= if_rdy_n;
      mem_ready_o <= mem_rdy_n;
      bus_err_o <= err_n;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of mem_bus_arbiter with a hand-driven bus slave.
module tb_mem_bus_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic if_ce_i = 1'b0, mem_ce_i = 1'b0, mem_we_i = 1'b0, bus_ack_i = 1'b0;
  logic [3:0] mem_sel_i = '0;
  logic [31:0] if_addr_i = '0, mem_addr_i = '0, mem_data_i = '0, bus_data_i = '0;
  logic [31:0] if_data_o, mem_data_o, bus_addr_o, bus_data_o;
  logic [3:0] bus_sel_o;
  logic if_ready_o, mem_ready_o, bus_ce_o, bus_we_o, stallreq_o, bus_err_o;
  int vec = 0, bad = 0;

  mem_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_ready_o(mem_ready_o),
    .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o), .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3 rst = 1'b1;
    #1;
    vec++;
    if ({bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, if_data_o, mem_data_o,
         if_ready_o, mem_ready_o, bus_err_o, stallreq_o} !== 138'h0) begin
      bad++;
      $display("FAIL reset_outputs: ce=%b we=%b sel=%h addr=%h wd=%h ifd=%h memd=%h rdy=%b%b err=%b stall=%b, want all 0",
               bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, if_data_o, mem_data_o,
               if_ready_o, mem_ready_o, bus_err_o, stallreq_o);
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    tick;
    tick;
    vec++;
    if ({bus_ce_o, stallreq_o} !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle: ce=%b stall=%b, want 00", bus_ce_o, stallreq_o);
    end
  endtask

  task automatic test_if_read;
    if_ce_i = 1'b1;
    if_addr_i = 32'h0000_0100;
    #1;
    vec++;
    if (stallreq_o !== 1'b1) begin
      bad++;
      $display("FAIL if_stall_pre: got %b want 1", stallreq_o);
    end
    tick;
    vec++;
    if ({bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o} !== {1'b1, 1'b0, 4'hf, 32'h100, 32'h0}) begin
      bad++;
      $display("FAIL if_bus: got ce=%b we=%b sel=%h addr=%h wd=%h want 1 0 f 00000100 00000000",
               bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o);
    end
    tick;
    tick;
    vec++;
    if ({bus_ce_o, bus_addr_o, if_ready_o, stallreq_o} !== {1'b1, 32'h100, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL if_hold: got ce=%b addr=%h rdy=%b stall=%b want 1 00000100 0 1",
               bus_ce_o, bus_addr_o, if_ready_o, stallreq_o);
    end
    bus_ack_i = 1'b1;
    bus_data_i = 32'hDEAD_BEEF;
    tick;
    bus_ack_i = 1'b0;
    bus_data_i = 32'h0;
    vec++;
    if ({if_ready_o, if_data_o, bus_ce_o, bus_we_o, stallreq_o} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL if_done: got rdy=%b data=%h ce=%b we=%b stall=%b want 1 deadbeef 0 0 0",
               if_ready_o, if_data_o, bus_ce_o, bus_we_o, stallreq_o);
    end
    tick;
    vec++;
    if ({if_ready_o, bus_ce_o} !== 2'b00) begin
      bad++;
      $display("FAIL if_no_reissue: got rdy=%b ce=%b want 00", if_ready_o, bus_ce_o);
    end
    if_ce_i = 1'b0;
    tick;
  endtask

  task automatic test_ack_idle;
    bus_ack_i = 1'b1;
    bus_data_i = 32'hFFFF_FFFF;
    tick;
    tick;
    tick;
    vec++;
    if ({bus_ce_o, if_ready_o, mem_ready_o, if_data_o} !== {3'b000, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL ack_idle: got ce=%b rdy=%b%b ifd=%h want 000 deadbeef",
               bus_ce_o, if_ready_o, mem_ready_o, if_data_o);
    end
    bus_ack_i = 1'b0;
    bus_data_i = 32'h0;
  endtask

  task automatic test_contention;
    if_ce_i = 1'b1;
    if_addr_i = 32'h0000_0300;
    mem_ce_i = 1'b1;
    mem_we_i = 1'b1;
    mem_sel_i = 4'hf;
    mem_addr_i = 32'h0000_0200;
    mem_data_i = 32'h1234_5678;
    tick;
    vec++;
    if ({bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o} !== {1'b1, 1'b1, 4'hf, 32'h200, 32'h1234_5678}) begin
      bad++;
      $display("FAIL cont_mem_first: got ce=%b we=%b sel=%h addr=%h wd=%h want 1 1 f 00000200 12345678",
               bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o);
    end
    bus_ack_i = 1'b1;
    tick;
    bus_ack_i = 1'b0;
    vec++;
    if ({mem_ready_o, if_ready_o, bus_ce_o, stallreq_o} !== 4'b1001) begin
      bad++;
      $display("FAIL cont_mem_done: got mrdy=%b irdy=%b ce=%b stall=%b want 1 0 0 1",
               mem_ready_o, if_ready_o, bus_ce_o, stallreq_o);
    end
    mem_ce_i = 1'b0;
    mem_we_i = 1'b0;
    tick;
    vec++;
    if ({bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, mem_ready_o} !== {1'b1, 1'b0, 4'hf, 32'h300, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL cont_if_next: got ce=%b we=%b sel=%h addr=%h wd=%h mrdy=%b want 1 0 f 00000300 00000000 0",
               bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, mem_ready_o);
    end
    bus_ack_i = 1'b1;
    bus_data_i = 32'hCAFE_F00D;
    tick;
    bus_ack_i = 1'b0;
    bus_data_i = 32'h0;
    vec++;
    if ({if_ready_o, mem_ready_o, if_data_o} !== {2'b10, 32'hCAFE_F00D}) begin
      bad++;
      $display("FAIL cont_if_done: got irdy=%b mrdy=%b data=%h want 1 0 cafef00d",
               if_ready_o, mem_ready_o, if_data_o);
    end
    if_ce_i = 1'b0;
    tick;
  endtask

  task automatic test_mem_read;
    mem_ce_i = 1'b1;
    mem_we_i = 1'b0;
    mem_sel_i = 4'hf;
    mem_addr_i = 32'h0000_0208;
    tick;
    bus_ack_i = 1'b1;
    bus_data_i = 32'h55AA_55AA;
    tick;
    bus_ack_i = 1'b0;
    bus_data_i = 32'h0;
    vec++;
    if ({mem_ready_o, mem_data_o} !== {1'b1, 32'h55AA_55AA}) begin
      bad++;
      $display("FAIL mem_read: got rdy=%b data=%h want 1 55aa55aa", mem_ready_o, mem_data_o);
    end
    mem_ce_i = 1'b0;
    tick;
  endtask

  task automatic test_halfword_store;
    mem_ce_i = 1'b1;
    mem_we_i = 1'b1;
    mem_sel_i = 4'b1100;
    mem_addr_i = 32'h0000_0204;
    mem_data_i = 32'hABCD_ABCD;
    tick;
    vec++;
    if ({bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o} !== {1'b1, 1'b1, 4'b1100, 32'h204, 32'hABCD_ABCD}) begin
      bad++;
      $display("FAIL hw_bus: got ce=%b we=%b sel=%b addr=%h wd=%h want 1 1 1100 00000204 abcdabcd",
               bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o);
    end
    bus_ack_i = 1'b1;
    bus_data_i = 32'h1111_1111;
    tick;
    bus_ack_i = 1'b0;
    bus_data_i = 32'h0;
    vec++;
    if ({mem_ready_o, mem_data_o, bus_ce_o, bus_we_o} !== {1'b1, 32'h55AA_55AA, 2'b00}) begin
      bad++;
      $display("FAIL hw_done: got rdy=%b data=%h ce=%b we=%b want 1 55aa55aa 0 0",
               mem_ready_o, mem_data_o, bus_ce_o, bus_we_o);
    end
    mem_ce_i = 1'b0;
    mem_we_i = 1'b0;
    tick;
    vec++;
    if (mem_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL hw_pulse_width: got rdy=%b want 0", mem_ready_o);
    end
  endtask

  task automatic test_reset_mid;
    mem_ce_i = 1'b1;
    mem_we_i = 1'b0;
    mem_sel_i = 4'hf;
    mem_addr_i = 32'h0000_020C;
    tick;
    vec++;
    if (bus_ce_o !== 1'b1) begin
      bad++;
      $display("FAIL rmid_busy: got ce=%b want 1", bus_ce_o);
    end
    #3 rst = 1'b1;
    #1;
    vec++;
    if ({bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, if_data_o, mem_data_o,
         if_ready_o, mem_ready_o, bus_err_o, stallreq_o} !== 138'h0) begin
      bad++;
      $display("FAIL rmid_async: ce=%b addr=%h ifd=%h memd=%h rdy=%b%b stall=%b, want all 0",
               bus_ce_o, bus_addr_o, if_data_o, mem_data_o, if_ready_o, mem_ready_o, stallreq_o);
    end
    tick;
    vec++;
    if ({bus_ce_o, mem_ready_o} !== 2'b00) begin
      bad++;
      $display("FAIL rmid_held: got ce=%b rdy=%b want 00", bus_ce_o, mem_ready_o);
    end
    rst = 1'b0;
    tick;
    vec++;
    if ({bus_ce_o, bus_addr_o, mem_ready_o} !== {1'b1, 32'h20C, 1'b0}) begin
      bad++;
      $display("FAIL rmid_reissue: got ce=%b addr=%h rdy=%b want 1 0000020c 0", bus_ce_o, bus_addr_o, mem_ready_o);
    end
    bus_ack_i = 1'b1;
    bus_data_i = 32'h0BAD_F00D;
    tick;
    bus_ack_i = 1'b0;
    bus_data_i = 32'h0;
    vec++;
    if ({mem_ready_o, mem_data_o} !== {1'b1, 32'h0BAD_F00D}) begin
      bad++;
      $display("FAIL rmid_done: got rdy=%b data=%h want 1 0badf00d", mem_ready_o, mem_data_o);
    end
    mem_ce_i = 1'b0;
    tick;
  endtask

  task automatic test_timeout;
    mem_ce_i = 1'b1;
    mem_we_i = 1'b0;
    mem_sel_i = 4'hf;
    mem_addr_i = 32'h0000_0400;
    tick;
`ifdef MEM_BUS_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick;
      vec++;
      if ({bus_ce_o, bus_err_o, mem_ready_o} !== 3'b100) begin
        bad++;
        $display("FAIL to_wait[%0d]: got ce=%b err=%b rdy=%b want 100", i, bus_ce_o, bus_err_o, mem_ready_o);
      end
    end
    tick;
    vec++;
    if ({bus_ce_o, bus_err_o, mem_ready_o, mem_data_o} !== {3'b011, 32'h0}) begin
      bad++;
      $display("FAIL to_abort: got ce=%b err=%b rdy=%b data=%h want 0 1 1 00000000",
               bus_ce_o, bus_err_o, mem_ready_o, mem_data_o);
    end
    mem_ce_i = 1'b0;
    tick;
    vec++;
    if ({bus_err_o, mem_ready_o} !== 2'b00) begin
      bad++;
      $display("FAIL to_pulse: got err=%b rdy=%b want 00", bus_err_o, mem_ready_o);
    end
`else
    for (int i = 0; i < 120; i++) begin
      tick;
      vec++;
      if ({bus_ce_o, bus_err_o, mem_ready_o} !== 3'b100) begin
        bad++;
        $display("FAIL no_to_hold[%0d]: got ce=%b err=%b rdy=%b want 100", i, bus_ce_o, bus_err_o, mem_ready_o);
      end
    end
    bus_ack_i = 1'b1;
    bus_data_i = 32'h7777_7777;
    tick;
    bus_ack_i = 1'b0;
    bus_data_i = 32'h0;
    vec++;
    if ({mem_ready_o, bus_err_o, mem_data_o} !== {2'b10, 32'h7777_7777}) begin
      bad++;
      $display("FAIL no_to_done: got rdy=%b err=%b data=%h want 1 0 77777777", mem_ready_o, bus_err_o, mem_data_o);
    end
    mem_ce_i = 1'b0;
    tick;
`endif
  endtask

  initial begin
    test_reset;
    test_if_read;
    test_ack_idle;
    test_contention;
    test_mem_read;
    test_halfword_store;
    test_reset_mid;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external single-port memory bus between the IF stage (instruction fetch) and the MEM stage (loads/stores incl. byte-lane selects from partial stores).
- Sequences multi-cycle bus transactions with an ack handshake and returns read data to the requester.
- Raises a pipeline stall request while either stage waits.
- Sits between the if/mem stage outputs and the bus/SRAM controller; stallreq_o feeds the pipeline ctrl block.

Parameters:
- TIMEOUT, 255: bus cycles without ack before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- if_ce_i  in  1  fetch request, level, held until if_ready_o
- if_addr_i  in  32  fetch address
- if_data_o  out  32  fetched instruction, registered
- if_ready_o  out  1  1-cycle pulse: fetch complete
- mem_ce_i  in  1  data request, level, held until mem_ready_o
- mem_we_i  in  1  1=store
- mem_sel_i  in  4  byte lanes
- mem_addr_i  in  32  data address
- mem_data_i  in  32  store data
- mem_data_o  out  32  load data, registered
- mem_ready_o  out  1  1-cycle pulse: data access complete
- bus_ce_o  out  1  bus cycle active, registered
- bus_we_o  out  1  bus write
- bus_sel_o  out  4  bus byte lanes
- bus_addr_o  out  32  bus address
- bus_data_o  out  32  bus write data
- bus_data_i  in  32  bus read data
- bus_ack_i  in  1  bus completion, sampled only while bus_ce_o=1
- stallreq_o  out  1  pipeline stall request
- bus_err_o  out  1  1-cycle pulse: transaction aborted (see optional feature)

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 (bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o, if_data_o, mem_data_o, both ready pulses, bus_err_o). A transaction in flight is dropped with no ready pulse; requester keeps ce high and is re-served after reset release.
- States: IDLE, IF_BUSY, MEM_BUSY.
- IDLE:
  - Eligible requester = ce_i high AND its ready_o not high this cycle. This suppresses re-issue in the cycle the requester sees its ready pulse.
  - MEM has fixed priority over IF (older instruction).
  - MEM grant: next cycle bus_ce_o=1; bus_we_o/sel/addr/data latch mem_*_i; go MEM_BUSY.
  - IF grant: bus_ce_o=1, we=0, sel=4'b1111, addr=if_addr_i, bus_data_o=0; go IF_BUSY.
  - No eligible requester: remain IDLE.
- BUSY states: bus outputs held stable until bus_ack_i=1. On ack:
  - bus_ce_o and bus_we_o drop to 0 next cycle.
  - Matching ready_o pulses high for exactly 1 cycle.
  - For reads, bus_data_i is captured into if_data_o/mem_data_o in the same edge.
  - Store completion leaves mem_data_o unchanged.
  - Return to IDLE.
- Latency: request seen at edge N → bus_ce_o from N+1 → ack earliest during cycle N+1 → ready at N+2. Minimum 2 cycles per transaction; one IDLE cycle between back-to-back transactions.
- bus_ack_i while IDLE: ignored. Requester dropping ce mid-transaction: the transaction still completes; the ready pulse is still generated and may be ignored.
- stallreq_o = (if_ce_i & ~if_ready_o) | (mem_ce_i & ~mem_ready_o). Combinational; 0 during reset.
- The arbiter passes mem_sel_i through as given; it does not check sel/addr alignment (e.g. sel=0000 is still a bus cycle).
- IF starvation under continuous MEM requests is acceptable; the stall from MEM freezes the front end anyway.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter clears on entering a BUSY state and increments each busy cycle without ack.
  - When count reaches TIMEOUT-1 with no ack, the transaction aborts next edge: bus_ce_o=0, the requester's ready pulses with data 32'h0, bus_err_o pulses 1 cycle, state→IDLE.
  - Ack in the same cycle as expiry wins: normal completion, no error.
- Not defined: no counter; BUSY waits indefinitely; bus_err_o tied 0; TIMEOUT unused.

Test Plan:
- Reset: rst=1 async mid-cycle → all outputs 0 immediately; after release with no ce, bus_ce_o stays 0.
- IF read: if_ce_i=1, addr 0x00000100; ack 3 cycles after bus_ce_o rises with data 0xDEADBEEF → bus_addr_o=0x100, sel=1111, we=0; if_ready_o 1-cycle pulse with if_data_o=0xDEADBEEF; stallreq_o high until that pulse; no second bus cycle.
- Contention: if_ce_i and mem_ce_i rise together; mem store addr 0x200, data 0x12345678, sel 1111 → MEM served first (bus_we_o=1); then one IDLE cycle; then IF read; mem_ready_o precedes if_ready_o.
- Halfword store: mem_we=1, sel=1100, addr 0x204, data 0xABCDABCD, immediate ack → bus_sel_o=1100 passed unchanged; mem_ready_o 1 cycle; mem_data_o unchanged.
- Reset mid-operation: rst pulsed in MEM_BUSY → bus_ce_o 0 at once, no mem_ready_o pulse; after release with mem_ce_i still high, the request is re-issued and completes normally.
- With MEM_BUS_TIMEOUT_EN, TIMEOUT=8, no ack → abort after 8 busy cycles; bus_err_o and mem_ready_o pulse together, mem_data_o=0. Without the macro → bus_ce_o held 100+ cycles, bus_err_o=0.
